// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART-driven ALU: default widths, opcode
// constants and the frame-assembly FSM state encoding.
package uart_alu_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int OP_W_DEF   = 6;
  localparam int OPC_W      = 6;

  localparam logic [OPC_W-1:0] OP_ADD = 6'b100000;
  localparam logic [OPC_W-1:0] OP_SUB = 6'b100010;
  localparam logic [OPC_W-1:0] OP_AND = 6'b100100;
  localparam logic [OPC_W-1:0] OP_OR  = 6'b100101;
  localparam logic [OPC_W-1:0] OP_XOR = 6'b100110;
  localparam logic [OPC_W-1:0] OP_NOR = 6'b100111;
  localparam logic [OPC_W-1:0] OP_SRA = 6'b000011;
  localparam logic [OPC_W-1:0] OP_SRL = 6'b000010;

  typedef enum logic [2:0] {
    GET_A  = 3'd0,
    GET_B  = 3'd1,
    GET_OP = 3'd2,
    EXEC   = 3'd3,
    SEND   = 3'd4
  } state_t;

endpackage

// File: rtl/uart_alu_intf_alu.sv
// Combinational ALU: result = f(A, B, op); unknown opcodes produce zero.
module alu
  import uart_alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OP_W   = OP_W_DEF
) (
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] result
);

  logic [OPC_W-1:0] opc;

  assign opc = OPC_W'(op);

  // Shifts by B >= DATA_W naturally saturate to sign fill (SRA) or zero (SRL).
  always_comb begin
    result = '0;
    case (opc)
      OP_ADD:  result = A + B;
      OP_SUB:  result = A - B;
      OP_AND:  result = A & B;
      OP_OR:   result = A | B;
      OP_XOR:  result = A ^ B;
      OP_NOR:  result = ~(A | B);
      OP_SRA:  result = $signed(A) >>> B;
      OP_SRL:  result = A >> B;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/uart_alu_intf.sv
// UART front end for the ALU: pops A, B, opcode bytes, executes, pushes result.
// Optional inter-byte timeout enabled by defining UART_ALU_INTF_TIMEOUT_EN.
module uart_alu_intf
  import uart_alu_pkg::*;
#(
  parameter int DATA_W         = DATA_W_DEF,
  parameter int OP_W           = OP_W_DEF,
  parameter int TIMEOUT_CYCLES = 2600000
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              rx_empty,
  input  logic [DATA_W-1:0] r_data,
  output logic              rd_uart,
  input  logic              tx_full,
  output logic [DATA_W-1:0] w_data,
  output logic              wr_uart,
  output logic [DATA_W-1:0] result_led,
  output state_t            dbg_state
);

  // Handshake: a byte is taken when the FIFO is non-empty (rx_empty=0) and no
  // pop strobe is outstanding; rd_uart/wr_uart are registered one-cycle strobes
  // that the FIFOs act on at the end of the cycle in which they are high.
  state_t            state, state_nxt;
  logic [DATA_W-1:0] a_q, b_q, res_q, alu_res;
  logic [OP_W-1:0]   op_q;
  logic              pop, push, abort, timeout_hit;

  alu #(.DATA_W(DATA_W), .OP_W(OP_W)) u_alu (
    .A      (a_q),
    .B      (b_q),
    .op     (op_q),
    .result (alu_res)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= GET_A;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    push      = 1'b0;
    abort     = 1'b0;
    case (state)
      GET_A: begin
        if (!rx_empty && !rd_uart) begin
          pop       = 1'b1;
          state_nxt = GET_B;
        end
      end
      GET_B: begin
        if (!rx_empty && !rd_uart) begin
          pop       = 1'b1;
          state_nxt = GET_OP;
        end else if (timeout_hit) begin
          abort     = 1'b1;
          state_nxt = GET_A;
        end
      end
      GET_OP: begin
        if (!rx_empty && !rd_uart) begin
          pop       = 1'b1;
          state_nxt = EXEC;
        end else if (timeout_hit) begin
          abort     = 1'b1;
          state_nxt = GET_A;
        end
      end
      EXEC: state_nxt = SEND;
      SEND: begin
        if (!tx_full && !wr_uart) begin
          push      = 1'b1;
          state_nxt = GET_A;
        end
      end
      default: state_nxt = GET_A;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      res_q      <= '0;
      rd_uart    <= 1'b0;
      wr_uart    <= 1'b0;
      w_data     <= '0;
      result_led <= '0;
    end else begin
      rd_uart <= pop;
      wr_uart <= push;
      if (pop && state == GET_A)  a_q  <= r_data;
      if (pop && state == GET_B)  b_q  <= r_data;
      if (pop && state == GET_OP) op_q <= r_data[OP_W-1:0];
      if (abort) begin
        a_q <= '0;
        b_q <= '0;
      end
      if (state == EXEC) res_q <= alu_res;
      if (push) begin
        w_data     <= res_q;
        result_led <= res_q;
      end
    end
  end

`ifdef UART_ALU_INTF_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt;
  logic            waiting;

  assign waiting     = (state == GET_B) || (state == GET_OP);
  assign timeout_hit = waiting && (to_cnt == TO_W'(TIMEOUT_CYCLES));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)                      to_cnt <= '0;
    else if (pop || timeout_hit)    to_cnt <= '0;
    else if (waiting)               to_cnt <= to_cnt + TO_W'(1);
    else                            to_cnt <= '0;
  end
`else
  // Without the timeout the limit is intentionally unused.
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  assign dbg_state = state;

endmodule
